truth_table_checker: RTL and testbench

- Synthesizable self-checking driver for combinational gates of the n2t family (and, or, xor, mux, …).
- On `start`, steps `dut_in` through all 2^N_IN input combinations in ascending order and lets each one settle. It then samples the single-bit `dut_out` and compares it with a truth table held in a parameter.
- Counts mismatches, records the first failing vector, and reports done/pass.
- Sits beside the gate under test in hardware-bring-up and regression tops: the driving/checking end of the gate's interface.

---
 rtl/truth_table_checker_pkg.sv | 13 +
 rtl/truth_table_checker_if.sv | 24 ++
 rtl/truth_table_checker_settle.sv | 26 ++
 rtl/truth_table_checker.sv | 100 ++++++++++
 tb/tb_truth_table_checker.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/truth_table_checker_pkg.sv
// Shared types and helpers for the n2t gate truth-table checker.
package n2t_check_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    localparam int SETTLE_MAX = 15;
    localparam int SETTLE_W   = 4;

    function automatic int vec_count(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Checker-to-gate bundle: stimulus/response plus sweep control and results.
interface truth_table_checker_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic            first_fail_valid;
    logic [N_IN-1:0] first_fail_vec;

    modport master (
        input  start, dut_out,
        output dut_in, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );

    modport slave (
        output start, dut_out,
        input  dut_in, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/truth_table_checker_settle.sv
// Loadable down-counter; expired is high in the last cycle a vector is held.
module settle_timer
    import n2t_check_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                expired
);

    logic [SETTLE_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - SETTLE_W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input combination of a gate, compares against EXPECTED, and reports results.
module truth_table_checker
    import n2t_check_pkg::*;
#(
    parameter int                    N_IN     = 2,
    parameter logic [(1<<N_IN)-1:0]  EXPECTED = 4'b1000,
    parameter int                    SETTLE   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    truth_table_checker_if.master   bus
);

    localparam int                  NV       = vec_count(N_IN);
    localparam logic [N_IN-1:0]     LAST_IDX = N_IN'(NV - 1);
    localparam logic [SETTLE_W-1:0] LOAD_VAL = SETTLE_W'(SETTLE - 1);

    state_t          state;
    logic [N_IN-1:0] idx;
    logic            busy_r;
    logic            done_r;
    logic [N_IN:0]   err_cnt;
    logic            ff_valid;
    logic [N_IN-1:0] ff_vec;
    logic            load;
    logic            expired;
    logic            mismatch;

    // The timer reloads on every edge that enters DRIVE, so each vector gets a fresh hold window.
    assign load = (((state == IDLE) || (state == DONE)) && bus.start)
                || ((state == CHECK) && (idx != LAST_IDX));

    assign mismatch = (bus.dut_out != EXPECTED[idx]);

    settle_timer u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (LOAD_VAL),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_cnt  <= '0;
            ff_valid <= 1'b0;
            ff_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state    <= DRIVE;
                        idx      <= '0;
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                        err_cnt  <= '0;
                        ff_valid <= 1'b0;
                        ff_vec   <= '0;
                    end
                end
                DRIVE: begin
                    if (expired) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + (N_IN+1)'(1);
                        if (!ff_valid) begin
                            ff_valid <= 1'b1;
                            ff_vec   <= idx;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        idx   <= idx + N_IN'(1);
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dut_in           = idx;
    assign bus.busy             = busy_r;
    assign bus.done             = done_r;
    assign bus.err_count        = err_cnt;
    assign bus.first_fail_valid = ff_valid;
    assign bus.first_fail_vec   = ff_vec;
    assign bus.pass             = done_r && (err_cnt == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: good AND, faulty OR, 3-input long-settle, restart and reset-mid-sweep.
module tb_truth_table_checker;

    logic clk;
    logic reset;

    truth_table_checker_if #(.N_IN(2)) ifa ();
    truth_table_checker_if #(.N_IN(2)) ifb ();
    truth_table_checker_if #(.N_IN(3)) ifc ();

    // Gates under test
    assign ifa.dut_out = &ifa.dut_in;
    assign ifb.dut_out = |ifb.dut_in;
    assign ifc.dut_out = &ifc.dut_in;

    truth_table_checker #(.N_IN(2), .EXPECTED(4'b1000), .SETTLE(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.master)
    );
    truth_table_checker #(.N_IN(2), .EXPECTED(4'b1000), .SETTLE(1)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.master)
    );
    truth_table_checker #(.N_IN(3), .EXPECTED(8'b1000_0000), .SETTLE(3)) dut_c (
        .clk(clk), .reset(reset), .bus(ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] din;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(input int w);
        case (w)
            0:       return ifa.done;
            1:       return ifb.done;
            default: return ifc.done;
        endcase
    endfunction

    // Returns number of cycles after the start edge until done is seen (bounded).
    task automatic wait_done(input int w, input int budget, output int n);
        n = 0;
        while (!done_of(w) && n < budget) begin
            step();
            n++;
        end
        if (!done_of(w)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done[%0d]: timed out after %0d cycles", w, n);
        end
    endtask

    task automatic pulse_start(input int w);
        case (w)
            0:       ifa.start = 1'b1;
            1:       ifb.start = 1'b1;
            default: ifc.start = 1'b1;
        endcase
        step();
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        tbl[0] = '{2'd0, 1'b1, 1'b0};
        tbl[1] = '{2'd0, 1'b1, 1'b0};
        tbl[2] = '{2'd1, 1'b1, 1'b0};
        tbl[3] = '{2'd1, 1'b1, 1'b0};
        tbl[4] = '{2'd2, 1'b1, 1'b0};
        tbl[5] = '{2'd2, 1'b1, 1'b0};
        tbl[6] = '{2'd3, 1'b1, 1'b0};
        tbl[7] = '{2'd3, 1'b1, 1'b0};
        tbl[8] = '{2'd3, 1'b0, 1'b1};

        ifa.start = 1'b0;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
        reset     = 1'b1;
        step();
        step();

        chk("rst_dut_in",  32'(ifa.dut_in), 0);
        chk("rst_busy",    32'(ifa.busy), 0);
        chk("rst_done",    32'(ifa.done), 0);
        chk("rst_pass",    32'(ifa.pass), 0);
        chk("rst_err",     32'(ifa.err_count), 0);
        chk("rst_ffv",     32'(ifa.first_fail_valid), 0);
        chk("rst_ffvec",   32'(ifa.first_fail_vec), 0);

        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("idle_busy", 32'(ifa.busy), 0);
        chk("idle_done", 32'(ifa.done), 0);

        // Good AND sweep, with a start pulse landing on edge 4 that must be ignored
        pulse_start(0);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("and_din[%0d]", k),  32'(ifa.dut_in), 32'(tbl[k].din));
            chk($sformatf("and_busy[%0d]", k), 32'(ifa.busy),   32'(tbl[k].busy));
            chk($sformatf("and_done[%0d]", k), 32'(ifa.done),   32'(tbl[k].done));
            ifa.start = (k == 3);
            step();
        end
        ifa.start = 1'b0;
        chk("and_pass", 32'(ifa.pass), 1);
        chk("and_err",  32'(ifa.err_count), 0);
        chk("and_ffv",  32'(ifa.first_fail_valid), 0);

        // Faulty gate: OR against AND table
        pulse_start(1);
        wait_done(1, 40, n);
        chk("or_latency", 32'(n), 8);
        chk("or_pass",    32'(ifb.pass), 0);
        chk("or_err",     32'(ifb.err_count), 2);
        chk("or_ffvec",   32'(ifb.first_fail_vec), 1);
        chk("or_ffv",     32'(ifb.first_fail_valid), 1);

        // Restart from DONE clears results on the start edge
        pulse_start(1);
        chk("rs_err",  32'(ifb.err_count), 0);
        chk("rs_ffv",  32'(ifb.first_fail_valid), 0);
        chk("rs_done", 32'(ifb.done), 0);
        chk("rs_busy", 32'(ifb.busy), 1);
        wait_done(1, 40, n);
        chk("rs_latency", 32'(n), 8);
        chk("rs_err2",    32'(ifb.err_count), 2);
        chk("rs_ffvec2",  32'(ifb.first_fail_vec), 1);

        // Three-input AND with SETTLE=3: each vector held for 4 cycles
        pulse_start(2);
        for (int j = 0; j < 32; j++) begin
            chk($sformatf("c_din[%0d]", j), 32'(ifc.dut_in), 32'(j / 4));
            if (j == 31) chk("c_done_early", 32'(ifc.done), 0);
            step();
        end
        chk("c_done",  32'(ifc.done), 1);
        chk("c_pass",  32'(ifc.pass), 1);
        chk("c_err",   32'(ifc.err_count), 0);

        // Reset at edge 5 of a fresh AND sweep
        pulse_start(0);
        for (int k = 1; k < 5; k++) step();
        chk("mid_busy_pre", 32'(ifa.busy), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_busy",   32'(ifa.busy), 0);
        chk("mid_done",   32'(ifa.done), 0);
        chk("mid_dut_in", 32'(ifa.dut_in), 0);
        chk("mid_err",    32'(ifa.err_count), 0);
        chk("mid_pass",   32'(ifa.pass), 0);
        step();
        chk("mid_idle", 32'(ifa.busy), 0);
        pulse_start(0);
        wait_done(0, 40, n);
        chk("mid_latency", 32'(n), 8);
        chk("mid_pass2",   32'(ifa.pass), 1);
        chk("mid_err2",    32'(ifa.err_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
